// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: ALU opcode encoding.
// Opcodes outside the enum make the ALU return zero.
package riscv_pkg;

  localparam int ALUOP_WIDTH = 4;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    ADD_OP     = 4'd0,
    SUB_OP     = 4'd1,
    SLL_OP     = 4'd2,
    SRL_OP     = 4'd3,
    SRA_OP     = 4'd4,
    SLT_OP     = 4'd5,
    SLTU_OP    = 4'd6,
    XOR_OP     = 4'd7,
    OR_OP      = 4'd8,
    AND_OP     = 4'd9,
    PASS_OP    = 4'd10,
    LOTOUPC_OP = 4'd11
  } alu_op_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Execute ALU bundle: op request in (i_*), tagged result out (o_*).
// master drives requests, slave is the ALU.
interface alu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 3
);

  logic                              i_valid;
  logic                              i_flush;
  logic [riscv_pkg::ALUOP_WIDTH-1:0] i_ALUOp;
  logic [DATA_WIDTH-1:0]             i_op1;
  logic [DATA_WIDTH-1:0]             i_op2;
  logic [TID_WIDTH-1:0]              i_tid;
  logic                              o_valid;
  logic [DATA_WIDTH-1:0]             o_result;
  logic                              o_zero;
  logic [TID_WIDTH-1:0]              o_tid;

  modport master (
    output i_valid, i_flush, i_ALUOp,
    output i_op1, i_op2, i_tid,
    input  o_valid, o_result, o_zero, o_tid
  );

  modport slave (
    input  i_valid, i_flush, i_ALUOp,
    input  i_op1, i_op2, i_tid,
    output o_valid, o_result, o_zero, o_tid
  );

endinterface

// File: rtl/alu_pipe.sv
// Execute-stage RV32I ALU (+ lower-to-upper case op), registered result with valid/tid.
// Ports: clk, rst_n (async low), bus (alu_pipe_if.slave). ALU_PIPE2_EN adds an input stage.
module alu_pipe
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  logic                   ex_valid;
  logic [ALUOP_WIDTH-1:0] ex_op;
  logic [DATA_WIDTH-1:0]  ex_a;
  logic [DATA_WIDTH-1:0]  ex_b;
  logic [TID_WIDTH-1:0]   ex_tid;

`ifdef ALU_PIPE2_EN
  logic                   s1_valid_q, s1_valid_d;
  logic [ALUOP_WIDTH-1:0] s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [TID_WIDTH-1:0]   s1_tid_q, s1_tid_d;

  // Operand regs only load on accepted ops so idle cycles don't toggle them.
  always_comb begin
    s1_valid_d = bus.i_valid & ~bus.i_flush;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tid_d   = s1_tid_q;
    if (s1_valid_d) begin
      s1_op_d  = bus.i_ALUOp;
      s1_a_d   = bus.i_op1;
      s1_b_d   = bus.i_op2;
      s1_tid_d = bus.i_tid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tid_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tid_q   <= s1_tid_d;
    end
  end

  assign ex_valid = s1_valid_q;
  assign ex_op    = s1_op_q;
  assign ex_a     = s1_a_q;
  assign ex_b     = s1_b_q;
  assign ex_tid   = s1_tid_q;
`else
  assign ex_valid = bus.i_valid;
  assign ex_op    = bus.i_ALUOp;
  assign ex_a     = bus.i_op1;
  assign ex_b     = bus.i_op2;
  assign ex_tid   = bus.i_tid;
`endif

  function automatic logic [DATA_WIDTH-1:0] alu_f(
    input logic [ALUOP_WIDTH-1:0] op,
    input logic [DATA_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0]  b
  );
    logic [4:0]            sh;
    logic [DATA_WIDTH-1:0] r;
    logic [7:0]            bt;
    sh = b[4:0];
    r  = '0;
    case (op)
      ADD_OP:  r = a + b;
      SUB_OP:  r = a - b;
      SLL_OP:  r = a << sh;
      SRL_OP:  r = a >> sh;
      SRA_OP:  r = $signed(a) >>> sh;
      SLT_OP:  r = {{(DATA_WIDTH-1){1'b0}},
                    $signed(a) < $signed(b)};
      SLTU_OP: r = {{(DATA_WIDTH-1){1'b0}}, a < b};
      XOR_OP:  r = a ^ b;
      OR_OP:   r = a | b;
      AND_OP:  r = a & b;
      PASS_OP: r = b;
      LOTOUPC_OP: begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
          bt = a[i*8 +: 8];
          if (bt >= 8'h61 && bt <= 8'h7A)
            bt = bt - 8'h20;
          r[i*8 +: 8] = bt;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;

  always_comb begin
    valid_d  = ex_valid & ~bus.i_flush;
    result_d = result_q;
    tid_d    = tid_q;
    if (valid_d) begin
      result_d = alu_f(ex_op, ex_a, ex_b);
      tid_d    = ex_tid;
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      tid_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      tid_q    <= tid_d;
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_zero   = zero_q;
  assign bus.o_tid    = tid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner ops plus random stream
// against a latency-line reference model.
module tb_alu_pipe;
  import riscv_pkg::*;

`ifdef ALU_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_pipe_if #(.DATA_WIDTH(32), .TID_WIDTH(3)) bus ();

  alu_pipe #(.DATA_WIDTH(32), .TID_WIDTH(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] r;
    logic [2:0]  t;
  } ent_t;

  ent_t        pend[$];
  bit          exp_v;
  logic [31:0] exp_r;
  logic [2:0]  exp_t;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int          sh;
    logic [31:0] r;
    sh = int'(b % 32);
    r  = 32'h0;
    if (op == ADD_OP)       r = a + b;
    else if (op == SUB_OP)  r = a + (~b) + 32'd1;
    else if (op == SLL_OP)  r = a << sh;
    else if (op == SRL_OP)  r = a >> sh;
    else if (op == SRA_OP) begin
      r = a >> sh;
      if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
    end
    else if (op == SLT_OP)
      r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
    else if (op == SLTU_OP) r = (a < b) ? 32'd1 : 32'd0;
    else if (op == XOR_OP)  r = a ^ b;
    else if (op == OR_OP)   r = a | b;
    else if (op == AND_OP)  r = a & b;
    else if (op == PASS_OP) r = b;
    else if (op == LOTOUPC_OP) begin
      r = a;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] c;
        c = 8'((a >> (8 * i)) & 32'hFF);
        if (c >= 8'h61 && c <= 8'h7A)
          r = r - (32'h20 << (8 * i));
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    ent_t e;
    pend.delete();
    e.v = 1'b0;
    e.r = 32'h0;
    e.t = 3'd0;
    for (int i = 0; i < LAT - 1; i++) pend.push_back(e);
    exp_v = 1'b0;
    exp_r = 32'h0;
    exp_t = 3'd0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(exp_v));
    chk({tag, ".result"}, bus.o_result, exp_r);
    chk({tag, ".zero"}, 32'(bus.o_zero), 32'(exp_r == 32'h0));
    chk({tag, ".tid"}, 32'(bus.o_tid), 32'(exp_t));
  endtask

  task automatic drive(input bit v, input bit f, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] t);
    bus.i_valid = v;
    bus.i_flush = f;
    bus.i_ALUOp = op;
    bus.i_op1   = a;
    bus.i_op2   = b;
    bus.i_tid   = t;
  endtask

  task automatic step(input string tag, input bit v, input bit f,
                      input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] t);
    ent_t e;
    ent_t n;
    drive(v, f, op, a, b, t);
    @(posedge clk);
    if (f)
      foreach (pend[i]) pend[i].v = 1'b0;
    n.v = v && !f;
    n.r = ref_alu(op, a, b);
    n.t = t;
    pend.push_back(n);
    e = pend.pop_front();
    exp_v = e.v;
    if (e.v) begin
      exp_r = e.r;
      exp_t = e.t;
    end
    #1;
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, ADD_OP, 32'h0, 32'h0, 3'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5, 0))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h6162_7A7B;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, ADD_OP, 32'd5, 32'd7, 3'd3);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_out("rst");

    chk("ref_sll", ref_alu(SLL_OP, 32'h8000_00F0, 32'hFFFF_FFE4), 32'h0000_0F00);
    chk("ref_srl", ref_alu(SRL_OP, 32'h8000_00F0, 32'hFFFF_FFE4), 32'h0800_000F);
    chk("ref_sra", ref_alu(SRA_OP, 32'h8000_00F0, 32'hFFFF_FFE4), 32'hF800_000F);
    chk("ref_luc", ref_alu(LOTOUPC_OP, 32'h617A_7B40, 32'h0), 32'h415A_7B40);

    @(negedge clk);
    rst_n = 1'b1;
    step("add1", 1'b1, 1'b0, ADD_OP, 32'd5, 32'd7, 3'd3);
    repeat (LAT - 1) idle("add1w");
    chk("add1_lat_res", bus.o_result, 32'd12);
    chk("add1_lat_v", 32'(bus.o_valid), 32'd1);

    step("sub", 1'b1, 1'b0, SUB_OP, 32'h8000_0000, 32'h8000_0000, 3'd1);
    step("addw", 1'b1, 1'b0, ADD_OP, 32'hFFFF_FFFF, 32'd1, 3'd2);
    step("slt", 1'b1, 1'b0, SLT_OP, 32'hFFFF_FFFF, 32'd1, 3'd3);
    step("sltu", 1'b1, 1'b0, SLTU_OP, 32'hFFFF_FFFF, 32'd1, 3'd4);
    step("sll", 1'b1, 1'b0, SLL_OP, 32'h8000_00F0, 32'hFFFF_FFE4, 3'd5);
    step("srl", 1'b1, 1'b0, SRL_OP, 32'h8000_00F0, 32'hFFFF_FFE4, 3'd6);
    step("sra", 1'b1, 1'b0, SRA_OP, 32'h8000_00F0, 32'hFFFF_FFE4, 3'd7);
    step("luc1", 1'b1, 1'b0, LOTOUPC_OP, 32'h617A_7B40, 32'h0, 3'd0);
    step("luc2", 1'b1, 1'b0, LOTOUPC_OP, 32'h6060_7A7A, 32'h0, 3'd1);

    for (int i = 0; i < 8; i++)
      step("b2b", 1'b1, 1'b0, XOR_OP, $urandom, $urandom, 3'(i));
    step("b2b_fl", 1'b1, 1'b1, ADD_OP, 32'd100, 32'd1, 3'd6);
    for (int i = 0; i < 4; i++)
      step("resume", 1'b1, 1'b0, OR_OP, $urandom, 32'h1, 3'(i));

    step("h1234", 1'b1, 1'b0, ADD_OP, 32'h1234, 32'h0, 3'd2);
    repeat (LAT) idle("hold");
    chk("hold_res", bus.o_result, 32'h1234);
    step("undef", 1'b1, 1'b0, 4'd13, 32'hDEAD_BEEF, 32'h1, 3'd4);
    repeat (LAT) idle("undefw");

    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(9, 0) < 8),
           ($urandom_range(19, 0) == 0),
           4'($urandom_range(15, 0)),
           pick(), pick(), 3'($urandom_range(7, 0)));
    end

    step("mid", 1'b1, 1'b0, ADD_OP, 32'd1, 32'd2, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst.result", bus.o_result, 32'h0);
    chk("mid_rst.zero", 32'(bus.o_zero), 32'd1);
    chk("mid_rst.tid", 32'(bus.o_tid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      step("post", 1'b1, 1'b0, 4'($urandom_range(11, 0)),
           pick(), pick(), 3'($urandom_range(7, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
